// File: rtl/cpu_mul_pkg.sv
`default_nettype none
// ============================================================================
// Module  : cpu_mul_pkg
// Purpose : Shared definitions for the pipelined CPU multiplier.
//           - Op encoding: MUL (low half) plus the three high-half variants
//           - Decode helpers: high-half select and per-operand signedness
// Ports   : none (package)
// Revision: 1.0 - initial release
// ============================================================================
package cpu_mul_pkg;

  localparam logic [1:0] OP_MUL    = 2'b00;
  localparam logic [1:0] OP_MULXSS = 2'b01;
  localparam logic [1:0] OP_MULXSU = 2'b10;
  localparam logic [1:0] OP_MULXUU = 2'b11;

  // Every op except MUL returns the upper half of the double-width product.
  function automatic logic op_is_high(input logic [1:0] op);
    return (op != OP_MUL);
  endfunction

  // src1 is treated as signed for MULXSS and MULXSU.
  function automatic logic op_src1_signed(input logic [1:0] op);
    return (op == OP_MULXSS) || (op == OP_MULXSU);
  endfunction

  // src2 is treated as signed only for MULXSS. The low half of the product
  // does not depend on signedness, so MUL zero-extends both operands.
  function automatic logic op_src2_signed(input logic [1:0] op);
    return (op == OP_MULXSS);
  endfunction

endpackage
`default_nettype wire

// File: rtl/cpu_mul_part_cell.sv
`default_nettype none
// ============================================================================
// Module  : cpu_mul_part_cell
// Purpose : One registered signed (PART_W+1)x(PART_W+1) multiplier. Written
//           as a plain multiply followed by a register so that it maps onto
//           a dedicated DSP block with its output register.
// Ports   : clk      in   clock
//           reset_n  in   asynchronous active-low clear of the product reg
//           i_en     in   load enable
//           i_a      in   signed limb, PART_W+1 bits
//           i_b      in   signed limb, PART_W+1 bits
//           o_p      out  registered signed product, 2*PART_W+2 bits
// Revision: 1.0 - initial release
// ============================================================================
module cpu_mul_part_cell #(
  parameter int PART_W = 16
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       i_en,
  input  logic signed [PART_W:0]     i_a,
  input  logic signed [PART_W:0]     i_b,
  output logic signed [2*PART_W+1:0] o_p
);

  logic signed [2*PART_W+1:0] r_p;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_p <= '0;
    end else if (i_en) begin
      r_p <= i_a * i_b;
    end
  end

  assign o_p = r_p;

endmodule
`default_nettype wire

// File: rtl/cpu_mul_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module  : cpu_mul_pipe_unit
// Purpose : Two-stage pipelined integer multiplier with valid/ready
//           handshakes, backpressure and flush. Operands are extended to
//           WIDTH+1 bits, split into signed limbs, multiplied in NPARTS^2
//           registered part cells (stage A), then shifted, summed and
//           half-selected into the output register (stage B).
// Ports   : clk         in   clock
//           reset_n     in   asynchronous active-low reset
//           flush       in   synchronous kill of all in-flight ops
//           in_valid    in   operands/op presented
//           in_ready    out  unit can accept this cycle
//           in_op       in   00 MUL, 01 MULXSS, 10 MULXSU, 11 MULXUU
//           in_src1     in   multiplicand, WIDTH bits
//           in_src2     in   multiplier, WIDTH bits
//           in_tag      in   sideband tag, TAG_W bits
//           out_valid   out  result valid
//           out_ready   in   consumer accepts result
//           out_result  out  selected product half, WIDTH bits
//           out_tag     out  tag of out_result
// Notes   : WIDTH must be a multiple of PART_W with WIDTH >= 2*PART_W.
// Revision: 1.0 - initial release
// ============================================================================
module cpu_mul_pipe_unit
  import cpu_mul_pkg::*;
#(
  parameter int WIDTH  = 32,
  parameter int PART_W = 16,
  parameter int TAG_W  = 5
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [1:0]       in_op,
  input  logic [WIDTH-1:0] in_src1,
  input  logic [WIDTH-1:0] in_src2,
  input  logic [TAG_W-1:0] in_tag,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [TAG_W-1:0] out_tag
);

  localparam int NPARTS = WIDTH / PART_W;
  localparam int NPP    = NPARTS * NPARTS;
  localparam int PPW    = 2 * PART_W + 2;   // part product width
  localparam int PW2    = 2 * WIDTH;        // full product width

  // --------------------------------------------------------------------------
  // Handshake
  // --------------------------------------------------------------------------
  logic             r_va;
  logic [1:0]       r_op_a;
  logic [TAG_W-1:0] r_tag_a;
  logic             r_out_valid;
  logic [WIDTH-1:0] r_out_result;
  logic [TAG_W-1:0] r_out_tag;

  logic w_adv_a;
  logic w_adv_b;
  logic w_acc;

  assign w_adv_b  = !r_out_valid || out_ready;
  assign w_adv_a  = !r_va || w_adv_b;
  // reset_n is folded in so nothing is accepted while reset is asserted.
  assign in_ready = w_adv_a && !flush && reset_n;
  assign w_acc    = in_valid && in_ready;

  // --------------------------------------------------------------------------
  // Operand extension and limb split
  // --------------------------------------------------------------------------
  logic [WIDTH:0] w_x1;
  logic [WIDTH:0] w_x2;

  assign w_x1 = {op_src1_signed(in_op) & in_src1[WIDTH-1], in_src1};
  assign w_x2 = {op_src2_signed(in_op) & in_src2[WIDTH-1], in_src2};

  // Lower limbs are non-negative ({0, bits}); the top limb carries the
  // extension bit and is the only one that can be negative.
  logic [NPARTS-1:0][PART_W:0] w_l1;
  logic [NPARTS-1:0][PART_W:0] w_l2;

  always_comb begin
    w_l1 = '0;
    w_l2 = '0;
    for (int i = 0; i < NPARTS; i++) begin
      if (i == NPARTS - 1) begin
        w_l1[i] = w_x1[WIDTH -: PART_W+1];
        w_l2[i] = w_x2[WIDTH -: PART_W+1];
      end else begin
        w_l1[i] = {1'b0, w_x1[i*PART_W +: PART_W]};
        w_l2[i] = {1'b0, w_x2[i*PART_W +: PART_W]};
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage A: part product cells plus op/tag/valid
  // --------------------------------------------------------------------------
  logic [NPP-1:0][PPW-1:0] w_pp;

  for (genvar gi = 0; gi < NPARTS; gi++) begin : g_row
    for (genvar gj = 0; gj < NPARTS; gj++) begin : g_col
      cpu_mul_part_cell #(
        .PART_W (PART_W)
      ) u_cell (
        .clk     (clk),
        .reset_n (reset_n),
        .i_en    (w_acc),
        .i_a     (w_l1[gi]),
        .i_b     (w_l2[gj]),
        .o_p     (w_pp[gi*NPARTS+gj])
      );
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_va    <= 1'b0;
      r_op_a  <= OP_MUL;
      r_tag_a <= '0;
    end else begin
      if (flush) begin
        r_va <= 1'b0;
      end else if (w_adv_a) begin
        r_va <= w_acc;
      end
      if (w_acc) begin
        r_op_a  <= in_op;
        r_tag_a <= in_tag;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Stage B: weighted sum of part products, half select, output register
  // --------------------------------------------------------------------------
  logic [PW2-1:0]   w_ext;
  logic [PW2-1:0]   w_prod;
  logic [WIDTH-1:0] w_res;

  // Part product (i,j) has weight 2^((i+j)*PART_W). Summing modulo 2^PW2
  // is exact for the bits kept.
  always_comb begin
    w_ext  = '0;
    w_prod = '0;
    for (int k = 0; k < NPP; k++) begin
      w_ext  = {{(PW2-PPW){w_pp[k][PPW-1]}}, w_pp[k]};
      w_prod = w_prod + (w_ext << (((k / NPARTS) + (k % NPARTS)) * PART_W));
    end
  end

  assign w_res = op_is_high(r_op_a) ? w_prod[PW2-1:WIDTH] : w_prod[WIDTH-1:0];

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_out_valid  <= 1'b0;
      r_out_result <= '0;
      r_out_tag    <= '0;
    end else begin
      if (flush) begin
        r_out_valid <= 1'b0;
      end else if (w_adv_b) begin
        r_out_valid <= r_va;
      end
      // Output data only moves when the holding register is free, so a
      // stalled result stays stable.
      if (w_adv_b && r_va) begin
        r_out_result <= w_res;
        r_out_tag    <= r_tag_a;
      end
    end
  end

  assign out_valid  = r_out_valid;
  assign out_result = r_out_result;
  assign out_tag    = r_out_tag;

endmodule
`default_nettype wire

// File: tb/tb_cpu_mul_pipe_unit.sv
`default_nettype none
// ============================================================================
// Module  : tb_cpu_mul_pipe_unit
// Purpose : Self-checking bench for cpu_mul_pipe_unit: directed vector table,
//           streaming, backpressure, flush, mid-operation reset and random
//           ops on two further parameterisations.
// Revision: 1.0 - initial release
// ============================================================================
module tb_cpu_mul_pipe_unit;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;
  int cyc      = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- main DUT (32/16) ----------------
  logic        reset_n, flush, in_valid, in_ready, out_valid, out_ready;
  logic [1:0]  in_op;
  logic [31:0] in_src1, in_src2, out_result;
  logic [4:0]  in_tag, out_tag;

  cpu_mul_pipe_unit #(.WIDTH(32), .PART_W(16), .TAG_W(5)) u_dut (
    .clk(clk), .reset_n(reset_n), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready), .in_op(in_op),
    .in_src1(in_src1), .in_src2(in_src2), .in_tag(in_tag),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_result(out_result), .out_tag(out_tag)
  );

  // ---------------- sweep DUTs (32/8 and 64/16) ----------------
  logic        s_flush, s_valid, s_ready;
  logic [1:0]  s_op;
  logic [4:0]  s_tag;
  logic        a_in_ready, a_out_valid, b_in_ready, b_out_valid;
  logic [31:0] a_src1, a_src2, a_res;
  logic [63:0] b_src1, b_src2, b_res;
  logic [4:0]  a_otag, b_otag;

  cpu_mul_pipe_unit #(.WIDTH(32), .PART_W(8), .TAG_W(5)) u_dut_a (
    .clk(clk), .reset_n(reset_n), .flush(s_flush),
    .in_valid(s_valid), .in_ready(a_in_ready), .in_op(s_op),
    .in_src1(a_src1), .in_src2(a_src2), .in_tag(s_tag),
    .out_valid(a_out_valid), .out_ready(s_ready),
    .out_result(a_res), .out_tag(a_otag)
  );

  cpu_mul_pipe_unit #(.WIDTH(64), .PART_W(16), .TAG_W(5)) u_dut_b (
    .clk(clk), .reset_n(reset_n), .flush(s_flush),
    .in_valid(s_valid), .in_ready(b_in_ready), .in_op(s_op),
    .in_src1(b_src1), .in_src2(b_src2), .in_tag(s_tag),
    .out_valid(b_out_valid), .out_ready(s_ready),
    .out_result(b_res), .out_tag(b_otag)
  );

  // ---------------- helpers ----------------
  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference: full double-width product of the extended operands.
  function automatic logic [63:0] ref_mul(input logic [1:0] op, input logic [63:0] a,
                                          input logic [63:0] b, input int w);
    logic [127:0] m, ea, eb, p;
    m  = (128'd1 << w) - 128'd1;
    ea = {64'd0, a} & m;
    eb = {64'd0, b} & m;
    if ((op == 2'b01 || op == 2'b10) && a[w-1]) ea = ea | ~m;
    if (op == 2'b01 && b[w-1]) eb = eb | ~m;
    p = ea * eb;
    if (op != 2'b00) p = p >> w;
    p = p & m;
    return p[63:0];
  endfunction

  function automatic logic [63:0] pick(input int w);
    logic [63:0] v;
    int sel;
    sel = $urandom_range(0, 7);
    v   = {$urandom, $urandom};
    if (sel == 0) v = '1;
    if (sel == 1) v = 64'd1 << (w - 1);
    if (sel == 2) v = 64'd0;
    return v;
  endfunction

  // ---------------- main DUT scoreboard ----------------
  logic        mon_en = 1'b0;
  logic [31:0] q_res[$];
  logic [4:0]  q_tag[$];
  int          n_out = 0, first_out = -1, last_out = -1;

  always @(negedge clk) begin
    if (mon_en && reset_n) begin
      if (out_valid && out_ready) begin
        chk("sb_underflow", 64'(q_res.size() != 0), 64'd1);
        if (q_res.size() != 0) begin
          chk("sb_result", 64'(out_result), 64'(q_res.pop_front()));
          chk("sb_tag", 64'(out_tag), 64'(q_tag.pop_front()));
        end
        n_out++;
        if (first_out < 0) first_out = cyc;
        last_out = cyc;
      end
      if (in_valid && in_ready) begin
        q_res.push_back(32'(ref_mul(in_op, {32'd0, in_src1}, {32'd0, in_src2}, 32)));
        q_tag.push_back(in_tag);
      end
    end
  end

  // ---------------- sweep scoreboards ----------------
  logic        sw_en = 1'b0;
  logic [31:0] qa_res[$];
  logic [63:0] qb_res[$];
  logic [4:0]  qa_tag[$], qb_tag[$];
  int          na_out = 0, nb_out = 0;

  always @(negedge clk) begin
    if (sw_en) begin
      if (a_out_valid) begin
        chk("sweepA_underflow", 64'(qa_res.size() != 0), 64'd1);
        if (qa_res.size() != 0) begin
          chk("sweepA_result", 64'(a_res), 64'(qa_res.pop_front()));
          chk("sweepA_tag", 64'(a_otag), 64'(qa_tag.pop_front()));
        end
        na_out++;
      end
      if (b_out_valid) begin
        chk("sweepB_underflow", 64'(qb_res.size() != 0), 64'd1);
        if (qb_res.size() != 0) begin
          chk("sweepB_result", b_res, qb_res.pop_front());
          chk("sweepB_tag", 64'(b_otag), 64'(qb_tag.pop_front()));
        end
        nb_out++;
      end
      if (s_valid && a_in_ready) begin
        qa_res.push_back(32'(ref_mul(s_op, {32'd0, a_src1}, {32'd0, a_src2}, 32)));
        qa_tag.push_back(s_tag);
      end
      if (s_valid && b_in_ready) begin
        qb_res.push_back(ref_mul(s_op, b_src1, b_src2, 64));
        qb_tag.push_back(s_tag);
      end
    end
  end

  // One op with exact-latency checks; assumes an idle pipeline and out_ready=1.
  task automatic apply_one(input string name, input logic [1:0] op, input logic [31:0] a,
                           input logic [31:0] b, input logic [4:0] tag, input logic [31:0] exp);
    @(posedge clk); #1;
    in_op = op; in_src1 = a; in_src2 = b; in_tag = tag; in_valid = 1'b1;
    @(negedge clk);
    chk({name, "_in_ready"}, 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk({name, "_early_valid"}, 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk({name, "_valid"}, 64'(out_valid), 64'd1);
    chk({name, "_result"}, 64'(out_result), 64'(exp));
    chk({name, "_tag"}, 64'(out_tag), 64'(tag));
  endtask

  typedef struct {
    logic [1:0]  op;
    logic [31:0] a;
    logic [31:0] b;
    logic [4:0]  tag;
    logic [31:0] exp;
  } vec_t;

  vec_t tbl[10];

  initial begin : watchdog
    #400000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end

  initial begin : main
    logic [31:0] bp_a[3], bp_b[3];
    logic [31:0] hold_r;
    logic [4:0]  hold_t;
    logic        held;
    int          idx, bound;

    tbl[0] = '{2'b00, 32'h0001_0003, 32'h0002_0005, 5'd3,  32'h000B_000F};
    tbl[1] = '{2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4,  32'h0000_0000};
    tbl[2] = '{2'b11, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd5,  32'hFFFF_FFFE};
    tbl[3] = '{2'b10, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd6,  32'hFFFF_FFFF};
    tbl[4] = '{2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd7,  32'h0000_0001};
    tbl[5] = '{2'b01, 32'h8000_0000, 32'h8000_0000, 5'd8,  32'h4000_0000};
    tbl[6] = '{2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 5'd9,  32'h8000_0000};
    tbl[7] = '{2'b11, 32'h8000_0000, 32'h0000_0002, 5'd10, 32'h0000_0001};
    tbl[8] = '{2'b00, 32'h1234_5678, 32'h0000_0010, 5'd11, 32'h2345_6780};
    tbl[9] = '{2'b01, 32'hFFFF_FFFE, 32'h0000_0003, 5'd31, 32'hFFFF_FFFF};

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
    in_op = 2'b00; in_src1 = '0; in_src2 = '0; in_tag = '0;
    s_flush = 1'b0; s_valid = 1'b0; s_ready = 1'b1; s_op = 2'b00; s_tag = '0;
    a_src1 = '0; a_src2 = '0; b_src1 = '0; b_src2 = '0;

    // Reset state
    #7;
    chk("reset_in_ready", 64'(in_ready), 64'd0);
    chk("reset_out_valid", 64'(out_valid), 64'd0);
    chk("reset_out_result", 64'(out_result), 64'd0);
    chk("reset_out_tag", 64'(out_tag), 64'd0);
    #5 reset_n = 1'b1;

    // Directed table
    for (int i = 0; i < 10; i++)
      apply_one($sformatf("vec%0d", i), tbl[i].op, tbl[i].a, tbl[i].b, tbl[i].tag, tbl[i].exp);

    // Streaming: 8 back-to-back random ops
    @(posedge clk); #1;
    mon_en = 1'b1; n_out = 0; first_out = -1; last_out = -1;
    for (int i = 0; i < 8; i++) begin
      in_op = 2'($urandom_range(0, 3));
      in_src1 = $urandom; in_src2 = $urandom; in_tag = 5'(i + 16);
      in_valid = 1'b1;
      @(negedge clk);
      chk("stream_in_ready", 64'(in_ready), 64'd1);
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    bound = 0;
    while ((q_res.size() != 0) && bound < 20) begin @(posedge clk); #1; bound++; end
    chk("stream_drained", 64'(q_res.size()), 64'd0);
    chk("stream_count", 64'(n_out), 64'd8);
    chk("stream_consecutive", 64'(last_out - first_out), 64'd7);

    // Backpressure: 3 ops offered with out_ready low
    bp_a = '{32'h0000_0007, 32'hDEAD_BEEF, 32'h8000_0001};
    bp_b = '{32'h0000_0009, 32'h0000_1000, 32'hFFFF_0000};
    n_out = 0;
    out_ready = 1'b0;
    idx = 0; held = 1'b0; hold_r = '0; hold_t = '0;
    for (int c = 0; c < 5; c++) begin
      @(posedge clk); #1;
      in_op = 2'b00; in_src1 = bp_a[idx]; in_src2 = bp_b[idx]; in_tag = 5'(idx + 1);
      in_valid = 1'b1;
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      else chk("bp_in_ready_low", 64'(in_ready), 64'd0);
      if (out_valid) begin
        if (!held) begin
          held = 1'b1; hold_r = out_result; hold_t = out_tag;
        end else begin
          chk("bp_hold_result", 64'(out_result), 64'(hold_r));
          chk("bp_hold_tag", 64'(out_tag), 64'(hold_t));
        end
      end
    end
    chk("bp_accepted", 64'(idx), 64'd2);
    chk("bp_out_valid_seen", 64'(held), 64'd1);
    @(posedge clk); #1;
    out_ready = 1'b1;
    bound = 0;
    while (idx < 3 && bound < 10) begin
      @(negedge clk);
      if (in_valid && in_ready) idx++;
      @(posedge clk); #1;
      bound++;
    end
    in_valid = 1'b0;
    chk("bp_third_accepted", 64'(idx), 64'd3);
    bound = 0;
    while ((q_res.size() != 0) && bound < 20) begin @(posedge clk); #1; bound++; end
    @(posedge clk); #1;
    chk("bp_drained", 64'(q_res.size()), 64'd0);
    chk("bp_out_count", 64'(n_out), 64'd3);
    mon_en = 1'b0;

    // Flush: A accepted, flushed next cycle while B is offered; C follows
    @(posedge clk); #1;
    in_op = 2'b00; in_src1 = 32'd5; in_src2 = 32'd6; in_tag = 5'd1; in_valid = 1'b1;
    @(negedge clk);
    chk("flush_a_accept", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    flush = 1'b1; in_src1 = 32'd7; in_src2 = 32'd8; in_tag = 5'd2;
    @(negedge clk);
    chk("flush_b_in_ready", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    flush = 1'b0; in_op = 2'b11; in_src1 = 32'h0001_0000; in_src2 = 32'h0003_0000; in_tag = 5'd3;
    @(negedge clk);
    chk("flush_no_valid_1", 64'(out_valid), 64'd0);
    chk("flush_c_in_ready", 64'(in_ready), 64'd1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    @(negedge clk);
    chk("flush_no_valid_2", 64'(out_valid), 64'd0);
    @(posedge clk); #1;
    chk("flush_c_valid", 64'(out_valid), 64'd1);
    chk("flush_c_result", 64'(out_result), 64'h0000_0003);
    chk("flush_c_tag", 64'(out_tag), 64'd3);

    // Asynchronous reset with two ops in flight
    @(posedge clk); #1;
    in_op = 2'b00; in_src1 = 32'd11; in_src2 = 32'd13; in_tag = 5'd9; in_valid = 1'b1;
    @(posedge clk); #1;
    in_src1 = 32'd17; in_tag = 5'd10;
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("rst_pre_valid", 64'(out_valid), 64'd1);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_out_valid", 64'(out_valid), 64'd0);
    chk("rst_out_result", 64'(out_result), 64'd0);
    chk("rst_out_tag", 64'(out_tag), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd0);
    #3 reset_n = 1'b1;
    apply_one("post_rst", 2'b01, 32'hFFFF_FFF0, 32'h0000_0100, 5'd12, 32'hFFFF_FFFF);

    // Random ops on WIDTH=32/PART_W=8 and WIDTH=64/PART_W=16
    @(posedge clk); #1;
    sw_en = 1'b1;
    for (int n = 0; n < 1000; n++) begin
      s_op   = 2'($urandom_range(0, 3));
      a_src1 = 32'(pick(32)); a_src2 = 32'(pick(32));
      b_src1 = pick(64);      b_src2 = pick(64);
      s_tag  = 5'(n);
      s_valid = 1'b1;
      @(posedge clk); #1;
    end
    s_valid = 1'b0;
    repeat (5) begin @(posedge clk); #1; end
    chk("sweepA_count", 64'(na_out), 64'd1000);
    chk("sweepB_count", 64'(nb_out), 64'd1000);
    chk("sweepA_drained", 64'(qa_res.size()), 64'd0);
    chk("sweepB_drained", 64'(qb_res.size()), 64'd0);
    sw_en = 1'b0;

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
